zbt_point_arbiter: RTL

Shares the single ZBT SRAM point-cloud buffer between the point writer (scanner or test-pattern source) and the renderer's point reader. It owns the ZBT address, write-enable and data-bus pins, and tracks the two-cycle ZBT data pipeline so writes and reads can interleave back-to-back with no turnaround. It also provides a memory-clear sequence. Each point is one 36-bit word: {6'b0, x[9:0], y[9:0], z[9:0]}, with signed two's-complement coordinates.

---
 rtl/zbt_pkg.sv | 27 ++
 rtl/zbt_pipe_tracker.sv | 43 ++++
 rtl/zbt_point_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/zbt_pkg.sv
// Shared constants, point-word layout and arbiter state type for the ZBT
// point-cloud buffer.
package zbt_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int ZBT_LAT    = 2;

    localparam int X_LSB   = 20;
    localparam int Y_LSB   = 10;
    localparam int Z_LSB   = 0;
    localparam int COORD_W = 10;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    function automatic logic [ZBT_DATA_W-1:0] make_point(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] z
    );
        return {6'b0, x, y, z};
    endfunction

endpackage

// File: rtl/zbt_pipe_tracker.sv
// Delay line following each granted access through the ZBT pipeline; drives the
// write-data bus timing and the read-capture strobe.
module zbt_pipe_tracker
    import zbt_pkg::*;
#(
    parameter int DATA_W = ZBT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_write,
    input  logic              issue_read,
    input  logic [DATA_W-1:0] issue_wdata,
    output logic [DATA_W-1:0] wdata,
    output logic              wdata_oe,
    output logic              rd_capture
);

    localparam int DEPTH = ZBT_LAT + 1;

    logic [DEPTH-1:0]  wr_pipe;
    logic [DEPTH-1:0]  rd_pipe;
    logic [DATA_W-1:0] data_pipe [DEPTH];

    // Stage 0 lines up with the registered address; the last stage is the
    // cycle the SRAM drives or expects the data bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pipe <= '0;
            rd_pipe <= '0;
            for (int i = 0; i < DEPTH; i++) data_pipe[i] <= '0;
        end else begin
            wr_pipe      <= {wr_pipe[DEPTH-2:0], issue_write};
            rd_pipe      <= {rd_pipe[DEPTH-2:0], issue_read};
            data_pipe[0] <= issue_write ? issue_wdata : '0;
            for (int i = 1; i < DEPTH; i++) data_pipe[i] <= data_pipe[i-1];
        end
    end

    assign wdata      = data_pipe[DEPTH-1];
    assign wdata_oe   = wr_pipe[DEPTH-1];
    assign rd_capture = rd_pipe[DEPTH-1];

endmodule

// File: rtl/zbt_point_arbiter.sv
// Arbitrates the ZBT point buffer between the point writer, the point reader and
// a memory-clear sequence. Optional statistics outputs: define ZBT_ARB_STATS_EN.
//
// state | meaning
// RUN   | serve writer and reader
// CLEAR | write zeros to indices 0..size-1 in cycles with no read grant
module zbt_point_arbiter
    import zbt_pkg::*;
#(
    parameter int ADDR_W = ZBT_ADDR_W,
    parameter int DATA_W = ZBT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] size,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              wr_start,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic              rd_urgent,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ZBT_ARB_STATS_EN
    ,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_rd_stall
`endif
);

    arb_state_t        state;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] clr_idx;
    logic              last_rd;

    logic              size_zero, clearing, wr_req, w_side, rd_win;
    logic              wr_gnt, wr_accept, clr_gnt, rd_capture;
    logic [ADDR_W:0]   wr_next, clr_next;
    logic              wr_last, wr_hit, clr_last;

    assign size_zero = (size == '0);
    assign clearing  = (state == CLEAR);
    assign wr_req    = !clearing && !size_zero && !wr_start && wr_valid;
    assign w_side    = wr_req || clearing;
    // last_rd set means the reader had the previous grant, so a contended
    // non-urgent cycle goes to the write side.
    assign rd_win    = rd_req && (rd_urgent || !w_side || !last_rd);
    assign wr_gnt    = w_side && !rd_win;
    assign wr_accept = wr_gnt && !clearing;
    assign clr_gnt   = wr_gnt && clearing;

    assign rd_gnt    = rd_win;
    assign wr_ready  = !clearing && !size_zero && !wr_start && !rd_win;
    assign clr_busy  = clearing;

    // One extra bit so an index left beyond a shrunk size still wraps.
    assign wr_next  = {1'b0, wr_idx} + (ADDR_W+1)'(1);
    assign clr_next = {1'b0, clr_idx} + (ADDR_W+1)'(1);
    assign wr_last  = (wr_next >= {1'b0, size});
    assign wr_hit   = (wr_next == {1'b0, size});
    assign clr_last = (clr_next >= {1'b0, size});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wr_idx   <= '0;
            clr_idx  <= '0;
            last_rd  <= 1'b0;
            wr_done  <= 1'b0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
        end else begin
            wr_done <= wr_accept && wr_hit;
            ram_we  <= wr_gnt;
            if (rd_win)         ram_addr <= rd_idx;
            else if (clr_gnt)   ram_addr <= clr_idx;
            else if (wr_accept) ram_addr <= wr_idx;
            if (rd_win || wr_gnt) last_rd <= rd_win;
            if (wr_start)       wr_idx <= '0;
            else if (wr_accept) wr_idx <= wr_last ? '0 : wr_next[ADDR_W-1:0];
            case (state)
                RUN: begin
                    if (clr && !size_zero) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_gnt) begin
                        if (clr_last) begin
                            state  <= RUN;
                            wr_idx <= '0;
                        end else begin
                            clr_idx <= clr_next[ADDR_W-1:0];
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    zbt_pipe_tracker #(.DATA_W(DATA_W)) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_write (wr_gnt),
        .issue_read  (rd_win),
        .issue_wdata (clearing ? '0 : wr_data),
        .wdata       (ram_wdata),
        .wdata_oe    (ram_wdata_oe),
        .rd_capture  (rd_capture)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_capture;
            if (rd_capture) rd_data <= ram_rdata;
        end
    end

`ifdef ZBT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_cnt   <= '0;
            stat_rd_stall <= '0;
        end else begin
            if (wr_accept && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (rd_req && !rd_win && stat_rd_stall != '1) stat_rd_stall <= stat_rd_stall + 32'd1;
        end
    end
`endif

endmodule
